// File: rtl/lc3_exec_pkg.sv
// Shared types and constants for the LC-3 operate-instruction execute sequencer.
// State encoding, LC-3 opcodes and the ALU opcode map driven on ALU_CONTROL.
package lc3_exec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ERR
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_AND   = 4'h1;
  localparam logic [3:0] ALU_NOT   = 4'h2;
  localparam logic [3:0] ALU_PASSA = 4'h3;

endpackage

// File: rtl/lc3_exec_decode.sv
// Combinational opcode decode: op -> {legal, alu_ctrl, uses_imm}.
// uses_imm marks opcodes whose IR[5] selects the immediate operand.
import lc3_exec_pkg::*;

module lc3_exec_decode (
  input  logic [3:0] op,
  output logic       legal,
  output logic [3:0] alu_ctrl,
  output logic       uses_imm
);

  always_comb begin
    legal    = 1'b0;
    alu_ctrl = ALU_PASSA;
    uses_imm = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        legal    = 1'b1;
        alu_ctrl = ALU_ADD;
        uses_imm = 1'b1;
      end
      (op == OP_AND): begin
        legal    = 1'b1;
        alu_ctrl = ALU_AND;
        uses_imm = 1'b1;
      end
      (op == OP_NOT): begin
        legal    = 1'b1;
        alu_ctrl = ALU_NOT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_exec_ctrl.sv
// LC-3 ADD/AND/NOT execute sequencer: IDLE->READ->EXEC->WB, illegal opcodes via ERR.
// Ports: decode handshake (IN_*), RF read/write, ALU mux/op, CC, DONE/ILLEGAL strobes.
// Define LC3_EXEC_PERF_EN to add RETIRED_CNT and saturating ILLEGAL_CNT outputs.
import lc3_exec_pkg::*;

module lc3_exec_ctrl #(
  parameter int unsigned READ_WAIT = 1,
  parameter logic [2:0]  CC_RESET  = 3'b001
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_IR,
  output logic [2:0]  SR1_ADDR,
  output logic [2:0]  SR2_ADDR,
  output logic        IS_IMMEDIATE,
  output logic [3:0]  ALU_CONTROL,
  input  logic [15:0] ALU_Y,
  input  logic [2:0]  ALU_NPZ,
  output logic        RF_WE,
  output logic [2:0]  RF_WADDR,
  output logic [15:0] RF_WDATA,
  output logic [2:0]  CC,
  output logic        DONE,
`ifdef LC3_EXEC_PERF_EN
  output logic [15:0] RETIRED_CNT,
  output logic [7:0]  ILLEGAL_CNT,
`endif
  output logic        ILLEGAL
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  npz_q, npz_d;
  logic [2:0]  cc_q, cc_d;

  logic [3:0]  dec_op;
  logic        dec_legal;
  logic [3:0]  dec_alu;
  logic        dec_imm;
  logic [1:0]  unused_ir;

  // In IDLE the incoming opcode is classified; afterwards IR_q drives decode.
  assign dec_op = (state_q == S_IDLE) ? IN_IR[15:12]
                                      : ir_q[15:12];

  lc3_exec_decode u_dec (
    .op       (dec_op),
    .legal    (dec_legal),
    .alu_ctrl (dec_alu),
    .uses_imm (dec_imm)
  );

  assign SR1_ADDR  = ir_q[8:6];
  assign SR2_ADDR  = ir_q[2:0];
  assign RF_WADDR  = ir_q[11:9];
  assign RF_WDATA  = wdata_q;
  assign CC        = cc_q;
  assign unused_ir = ir_q[4:3];

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    npz_d        = npz_q;
    cc_d         = cc_q;
    IN_READY     = 1'b0;
    IS_IMMEDIATE = 1'b0;
    ALU_CONTROL  = ALU_PASSA;
    RF_WE        = 1'b0;
    DONE         = 1'b0;
    ILLEGAL      = 1'b0;
    case (state_q)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          ir_d    = IN_IR;
          cnt_d   = READ_WAIT[1:0];
          state_d = dec_legal ? S_READ : S_ERR;
        end
      end
      S_READ: begin
        IS_IMMEDIATE = dec_imm & ir_q[5];
        ALU_CONTROL  = dec_alu;
        if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
        else               state_d = S_EXEC;
      end
      S_EXEC: begin
        IS_IMMEDIATE = dec_imm & ir_q[5];
        ALU_CONTROL  = dec_alu;
        wdata_d      = ALU_Y;
        npz_d        = ALU_NPZ;
        state_d      = S_WB;
      end
      S_WB: begin
        IS_IMMEDIATE = dec_imm & ir_q[5];
        ALU_CONTROL  = dec_alu;
        RF_WE        = 1'b1;
        DONE         = 1'b1;
        cc_d         = npz_q;
        state_d      = S_IDLE;
      end
      S_ERR: begin
        ILLEGAL = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      npz_q   <= '0;
      cc_q    <= CC_RESET;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      npz_q   <= npz_d;
      cc_q    <= cc_d;
    end
  end

`ifdef LC3_EXEC_PERF_EN
  logic [15:0] ret_q, ret_d;
  logic [7:0]  ill_q, ill_d;

  always_comb begin
    ret_d = ret_q;
    ill_d = ill_q;
    if (DONE) ret_d = ret_q + 16'd1;
    if (ILLEGAL && ill_q != 8'hFF)
      ill_d = ill_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ret_q <= '0;
      ill_q <= '0;
    end else begin
      ret_q <= ret_d;
      ill_q <= ill_d;
    end
  end

  assign RETIRED_CNT = ret_q;
  assign ILLEGAL_CNT = ill_q;
`endif

endmodule
